// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready handshake.
// Carries a packed DATA_W payload between CPU stages, with pause (freeze), flush
// (bubble insertion), an optional 2-entry skid buffer and a saturating stall counter.
//
// Ports:
//   clk_50MHz, rst (async, active-low)
//   pause, flush                      - stage control
//   in_valid / in_ready / in_data     - upstream handshake
//   out_valid / out_ready / out_data  - downstream handshake (out_data = BUBBLE when idle)
//   occupancy                         - entries held (0..2)
//   cnt_clr / stall_cnt               - saturating count of stalled upstream cycles
module pipe_stage_reg #(
  parameter int unsigned        DATA_W = 128,
  parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
  parameter int unsigned        SKID   = 1,
  parameter int unsigned        CNT_W  = 16
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              pause,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam bit HAS_SKID = (SKID != 0);

  logic              m_v_q, m_v_d;
  logic [DATA_W-1:0] m_d_q, m_d_d;
  logic              s_v_q, s_v_d;
  logic [DATA_W-1:0] s_d_q, s_d_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept;
  logic              drain;

  // Handshake: with a skid entry in_ready depends only on local state.
  always_comb begin
    if (HAS_SKID) in_ready = ~s_v_q & ~pause;
    else          in_ready = (~m_v_q | out_ready) & ~pause;
    out_valid = m_v_q & ~pause;
    // Gated so a paused-but-full stage still presents BUBBLE while idle.
    out_data  = out_valid ? m_d_q : BUBBLE;
    accept    = in_valid & in_ready;
    drain     = out_valid & out_ready;
    occupancy = 2'(m_v_q) + 2'(s_v_q);
    stall_cnt = stall_cnt_q;
  end

  // Next state of main/skid entries; empty entries always hold BUBBLE.
  always_comb begin
    m_v_d = m_v_q;
    m_d_d = m_d_q;
    s_v_d = s_v_q;
    s_d_d = s_d_q;
    if (flush) begin
      // A drain this cycle completes downstream; an accept is dropped.
      m_v_d = 1'b0;
      m_d_d = BUBBLE;
      s_v_d = 1'b0;
      s_d_d = BUBBLE;
    end else if (pause) begin
      // Hold everything; handshakes are blocked so no transfer happens.
    end else if (HAS_SKID) begin
      if (drain && s_v_q) begin
        m_v_d = 1'b1;
        m_d_d = s_d_q;
        s_v_d = 1'b0;
        s_d_d = BUBBLE;
      end else if (drain) begin
        m_v_d = accept;
        m_d_d = accept ? in_data : BUBBLE;
      end else if (!m_v_q) begin
        if (accept) begin
          m_v_d = 1'b1;
          m_d_d = in_data;
        end
      end else if (accept) begin
        s_v_d = 1'b1;
        s_d_d = in_data;
      end
    end else begin
      if (accept) begin
        m_v_d = 1'b1;
        m_d_d = in_data;
      end else if (drain) begin
        m_v_d = 1'b0;
        m_d_d = BUBBLE;
      end
      s_v_d = 1'b0;
      s_d_d = BUBBLE;
    end
  end

  // Stall counter: clear wins, saturates at all-ones, unaffected by flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (in_valid && !in_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      m_v_q       <= 1'b0;
      m_d_q       <= BUBBLE;
      s_v_q       <= 1'b0;
      s_d_q       <= BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      m_v_q       <= m_v_d;
      m_d_q       <= m_d_d;
      s_v_q       <= s_v_d;
      s_d_q       <= s_d_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: one SKID=1 and one SKID=0 instance (DATA_W=16, CNT_W=4).
// Stimulus pushes accepted beats into per-instance queues; a monitor pops them on drain.
module tb_pipe_stage_reg;

  logic clk_50MHz;
  logic rst;

  logic        a_pause, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_clr;
  logic [15:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [3:0]  a_cnt;

  logic        b_pause, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_clr;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [3:0]  b_cnt;

  int n_vec;
  int n_err;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  // Backpressure vectors: in_valid, in_data, out_ready, expected in_ready, expected occupancy.
  bit          bp_iv [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [15:0] bp_d  [9] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0013,
                             16'h0013, 16'h0013, 16'h0014, 16'h0015};
  bit          bp_or [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
  bit          bp_ir [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
  logic [1:0]  bp_oc [9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};

  pipe_stage_reg #(.DATA_W(16), .BUBBLE(16'h0000), .SKID(1), .CNT_W(4)) u_dut_a (
    .clk_50MHz (clk_50MHz), .rst (rst), .pause (a_pause), .flush (a_flush),
    .in_valid  (a_in_valid), .in_ready (a_in_ready), .in_data (a_in_data),
    .out_valid (a_out_valid), .out_ready (a_out_ready), .out_data (a_out_data),
    .occupancy (a_occ), .cnt_clr (a_cnt_clr), .stall_cnt (a_cnt)
  );

  pipe_stage_reg #(.DATA_W(16), .BUBBLE(16'h0000), .SKID(0), .CNT_W(4)) u_dut_b (
    .clk_50MHz (clk_50MHz), .rst (rst), .pause (b_pause), .flush (b_flush),
    .in_valid  (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data),
    .out_valid (b_out_valid), .out_ready (b_out_ready), .out_data (b_out_data),
    .occupancy (b_occ), .cnt_clr (b_cnt_clr), .stall_cnt (b_cnt)
  );

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record beats the bench offered and the stage took, then advance one cycle.
  task automatic tick();
    @(negedge clk_50MHz);
    if (rst && a_in_valid && a_in_ready && !a_flush) exp_a.push_back(a_in_data);
    if (rst && b_in_valid && b_in_ready && !b_flush) exp_b.push_back(b_in_data);
    @(posedge clk_50MHz);
    #1;
  endtask

  // Output monitor: order check on every drain, bubble check while idle.
  always @(negedge clk_50MHz) begin
    if (a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_extra_beat: got %h, expected no beat (t=%0t)", a_out_data, $time);
      end else chk("a_order", 32'(a_out_data), 32'(exp_a.pop_front()));
    end
    if (!a_out_valid) chk("a_bubble", 32'(a_out_data), 32'h0);
    if (b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_extra_beat: got %h, expected no beat (t=%0t)", b_out_data, $time);
      end else chk("b_order", 32'(b_out_data), 32'(exp_b.pop_front()));
    end
    if (!b_out_valid) chk("b_bubble", 32'(b_out_data), 32'h0);
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    a_pause = 0; a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_cnt_clr = 0;
    b_pause = 0; b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_cnt_clr = 0;
    #2 rst = 1'b0;
    #1;
    chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_out_data", 32'(a_out_data), 32'h0);
    chk("rst_a_occ", 32'(a_occ), 32'd0);
    chk("rst_a_cnt", 32'(a_cnt), 32'd0);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    repeat (2) @(posedge clk_50MHz);
    @(negedge clk_50MHz) rst = 1'b1;
    @(posedge clk_50MHz); #1;

    // SKID=0 pass-through: same-cycle drain and accept, then combinational backpressure.
    b_in_valid = 1; b_in_data = 16'h0033; b_out_ready = 0;
    tick();
    b_in_data = 16'h0034; b_out_ready = 1;
    #1 chk("b_pass_in_ready", 32'(b_in_ready), 32'd1);
    tick();
    b_in_data = 16'h0035; b_out_ready = 0;
    #1;
    chk("b_pass_out_data", 32'(b_out_data), 32'h0034);
    chk("b_full_in_ready", 32'(b_in_ready), 32'd0);
    chk("b_occ", 32'(b_occ), 32'd1);
    tick();
    b_in_valid = 0; b_out_ready = 1;
    #1 chk("b_cnt", 32'(b_cnt), 32'd1);
    tick();
    b_out_ready = 0;

    // SKID=1 stream: back-to-back beats, one cycle latency.
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = 16'(i);
      #1;
      chk("stream_in_ready", 32'(a_in_ready), 32'd1);
      chk("stream_occ_le1", 32'(a_occ <= 2'd1), 32'd1);
      if (i > 1) chk("stream_latency", 32'(a_out_data), 32'(i - 1));
      tick();
    end
    a_in_valid = 0;
    repeat (2) tick();

    // Backpressure: skid fills, in_ready low for three cycles, order kept.
    for (int c = 0; c < 9; c++) begin
      a_in_valid = bp_iv[c]; a_in_data = bp_d[c]; a_out_ready = bp_or[c];
      #1;
      chk("bp_in_ready", 32'(a_in_ready), 32'(bp_ir[c]));
      chk("bp_occ", 32'(a_occ), 32'(bp_oc[c]));
      if (c == 6) chk("bp_stall_cnt", 32'(a_cnt), 32'd3);
      tick();
    end
    a_in_valid = 0;
    repeat (3) tick();

    // Flush with skid full and a beat on the input.
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 16'h0020; tick();
    a_in_data = 16'h0021; tick();
    a_in_data = 16'hBEEF; a_flush = 1;
    #1 chk("flush_pre_occ", 32'(a_occ), 32'd2);
    tick();
    exp_a.delete();
    a_flush = 0; a_in_valid = 0;
    #1;
    chk("flush_occ", 32'(a_occ), 32'd0);
    chk("flush_out_valid", 32'(a_out_valid), 32'd0);
    chk("flush_out_data", 32'(a_out_data), 32'h0);
    chk("flush_in_ready", 32'(a_in_ready), 32'd1);
    chk("flush_cnt", 32'(a_cnt), 32'd4);

    // Pause for 4 cycles, then pause together with flush.
    a_in_valid = 1; a_in_data = 16'h00AA; tick();
    a_pause = 1; a_in_data = 16'h00AB;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("pause_out_valid", 32'(a_out_valid), 32'd0);
      chk("pause_in_ready", 32'(a_in_ready), 32'd0);
      chk("pause_occ", 32'(a_occ), 32'd1);
      tick();
    end
    a_pause = 0; a_in_valid = 0;
    #1;
    chk("pause_held_data", 32'(a_out_data), 32'h00AA);
    chk("pause_cnt", 32'(a_cnt), 32'd8);
    tick();
    a_pause = 1; a_flush = 1;
    tick();
    exp_a.delete();
    a_pause = 0; a_flush = 0;
    #1;
    chk("pflush_occ", 32'(a_occ), 32'd0);
    chk("pflush_out_valid", 32'(a_out_valid), 32'd0);

    // Counter saturation, then clear colliding with an increment.
    a_pause = 1; a_in_valid = 1; a_in_data = 16'h0077;
    repeat (20) tick();
    chk("sat_cnt", 32'(a_cnt), 32'd15);
    a_cnt_clr = 1; tick();
    a_cnt_clr = 0;
    chk("clr_cnt", 32'(a_cnt), 32'd0);
    tick();
    chk("clr_resume_cnt", 32'(a_cnt), 32'd1);
    a_pause = 0; a_in_valid = 0;
    tick();

    // Async reset asserted mid-stream.
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 16'h0040; tick();
    a_in_data = 16'h0041;
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(a_out_valid), 32'd0);
    chk("arst_out_data", 32'(a_out_data), 32'h0);
    chk("arst_occ", 32'(a_occ), 32'd0);
    chk("arst_cnt", 32'(a_cnt), 32'd0);
    chk("arst_in_ready", 32'(a_in_ready), 32'd1);
    a_in_valid = 0;
    exp_a.delete();
    @(negedge clk_50MHz) rst = 1'b1;
    @(posedge clk_50MHz); #1;
    tick();

    chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
